instr_fetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core. It owns the program counter and issues one word request at a time to the instruction memory port. It presents `PC_out`/`instruction_out` to the decode stage's `PC_in`/`instruction_in` inputs. It honours the same `stall` (hazard unit) and `flush` (branch/jump resolution) signals that decode receives, and holds a returned instruction in a one-entry skid buffer while the pipeline is stalled.

---
 rtl/instr_fetch.sv | 150 +++++++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage and IF/ID register with a one-entry skid buffer.
// Defining IF_STATIC_PREDICT_EN enables backward-branch/JAL static prediction.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        pred_taken_out
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_SKID} state_t;

  state_t      state, state_next;
  logic [31:0] pc, inflight_pc, skid_pc, skid_insn, flush_pc;
  logic        req_q;
  logic        load_ifid;
  logic [31:0] load_pc, load_insn;
  logic        pred_hit;
  logic [31:0] pred_target;

  assign flush_pc  = flush_target & ~32'd3;
  assign imem_req  = req_q;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // A flush must still swallow any response that is already owed to us.
  always_comb begin
    state_next = state;
    if (flush) begin
      if ((state == S_WAIT || state == S_DROP) && !imem_rvalid) state_next = S_DROP;
      else if (state == S_REQ && imem_gnt)                      state_next = S_DROP;
      else                                                      state_next = S_REQ;
    end else begin
      case (state)
        S_IDLE:  state_next = S_REQ;
        S_REQ:   if (imem_gnt) state_next = S_WAIT;
        S_WAIT:  if (imem_rvalid) state_next = stall ? S_SKID : S_REQ;
        S_DROP:  if (imem_rvalid) state_next = S_REQ;
        S_SKID:  if (!stall) state_next = S_REQ;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    load_ifid = 1'b0;
    load_pc   = skid_pc;
    load_insn = skid_insn;
    if (!flush && !stall) begin
      if (state == S_WAIT && imem_rvalid) begin
        load_ifid = 1'b1;
        load_pc   = inflight_pc;
        load_insn = imem_rdata;
      end else if (state == S_SKID) begin
        load_ifid = 1'b1;
      end
    end
  end

`ifdef IF_STATIC_PREDICT_EN
  logic [31:0] b_imm, j_imm;

  // Backward conditional branches and all JALs are predicted taken.
  always_comb begin
    b_imm       = {{20{load_insn[31]}}, load_insn[7], load_insn[30:25], load_insn[11:8], 1'b0};
    j_imm       = {{12{load_insn[31]}}, load_insn[19:12], load_insn[20], load_insn[30:21], 1'b0};
    pred_hit    = 1'b0;
    pred_target = load_pc;
    if (load_insn[6:0] == 7'b1100011 && load_insn[31]) begin
      pred_hit    = 1'b1;
      pred_target = load_pc + b_imm;
    end else if (load_insn[6:0] == 7'b1101111) begin
      pred_hit    = 1'b1;
      pred_target = load_pc + j_imm;
    end
  end
`else
  assign pred_hit    = 1'b0;
  assign pred_target = load_pc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      req_q       <= 1'b0;
    end else begin
      req_q <= (state_next == S_REQ);
      if (flush)                   pc <= flush_pc;
      else if (load_ifid && pred_hit) pc <= pred_target;
      else if (state == S_REQ && imem_gnt) pc <= pc + 32'd4;
      if (state == S_REQ && imem_gnt) inflight_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_pc   <= RESET_PC;
      skid_insn <= NOP_INSN;
    end else if (flush) begin
      skid_insn <= NOP_INSN;
    end else if (state == S_WAIT && imem_rvalid && stall) begin
      skid_pc   <= inflight_pc;
      skid_insn <= imem_rdata;
    end
  end

  // Empty non-stall cycles insert a bubble but keep the last PC for debug.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_out          <= RESET_PC;
      instruction_out <= NOP_INSN;
      valid_out       <= 1'b0;
      pred_taken_out  <= 1'b0;
    end else if (flush) begin
      PC_out          <= flush_pc;
      instruction_out <= NOP_INSN;
      valid_out       <= 1'b0;
      pred_taken_out  <= 1'b0;
    end else if (!stall) begin
      if (load_ifid) begin
        PC_out          <= load_pc;
        instruction_out <= load_insn;
        valid_out       <= 1'b1;
        pred_taken_out  <= pred_hit;
      end else begin
        instruction_out <= NOP_INSN;
        valid_out       <= 1'b0;
        pred_taken_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch, stall/skid, flush/drop, grant wait,
// PC wrap and asynchronous reset for instr_fetch.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, flush, imem_gnt, imem_rvalid;
  logic [31:0] flush_target, imem_rdata;
  logic        imem_req, valid_out, pred_taken_out;
  logic [31:0] imem_addr, PC_out, instruction_out;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr;
  logic        exp_pred;

  instr_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .flush_target(flush_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_out(PC_out), .instruction_out(instruction_out), .valid_out(valid_out),
    .pred_taken_out(pred_taken_out)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic st, input logic fl, input logic [31:0] ft,
                                input logic gnt, input logic rv, input logic [31:0] rd);
    stall        = st;
    flush        = fl;
    flush_target = ft;
    imem_gnt     = gnt;
    imem_rvalid  = rv;
    imem_rdata   = rd;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step(); step();
    check_output("rst_req",   imem_req,        0);
    check_output("rst_addr",  imem_addr,       0);
    check_output("rst_pc",    PC_out,          0);
    check_output("rst_insn",  instruction_out, NOP);
    check_output("rst_valid", valid_out,       0);
    check_output("rst_pred",  pred_taken_out,  0);

    // zero-wait fetch of words at 0 and 4
    reset = 1'b1;
    step();
    check_output("f0_req",  imem_req,  1);
    check_output("f0_addr", imem_addr, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    check_output("f0_wait_req", imem_req, 0);
    apply_stimulus(0, 0, 0, 0, 1, 32'h0050_0093);
    step();
    check_output("f0_pc",    PC_out,          0);
    check_output("f0_insn",  instruction_out, 32'h0050_0093);
    check_output("f0_valid", valid_out,       1);
    check_output("f1_req",   imem_req,        1);
    check_output("f1_addr",  imem_addr,       4);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    check_output("bubble_insn",  instruction_out, NOP);
    check_output("bubble_valid", valid_out,       0);
    check_output("bubble_pc",    PC_out,          0);
    apply_stimulus(0, 0, 0, 0, 1, 32'h00A0_0113);
    step();
    check_output("f1_pc",    PC_out,          4);
    check_output("f1_insn",  instruction_out, 32'h00A0_0113);
    check_output("f1_valid", valid_out,       1);
    check_output("f2_addr",  imem_addr,       8);

    // stall 3 cycles while the word at 8 returns into the skid buffer
    apply_stimulus(1, 0, 0, 1, 0, 0);
    step();
    check_output("st_req0",  imem_req,        0);
    check_output("st_hold0", instruction_out, 32'h00A0_0113);
    apply_stimulus(1, 0, 0, 0, 1, 32'h0030_8193);
    step();
    check_output("st_req1",   imem_req,  0);
    check_output("st_hold1",  PC_out,    4);
    check_output("st_valid1", valid_out, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    step();
    check_output("st_req2",  imem_req,        0);
    check_output("st_hold2", instruction_out, 32'h00A0_0113);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    check_output("skid_pc",    PC_out,          8);
    check_output("skid_insn",  instruction_out, 32'h0030_8193);
    check_output("skid_valid", valid_out,       1);
    check_output("skid_addr",  imem_addr,       32'hC);

    // flush while the request to 0xC is outstanding
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(0, 1, 32'h100, 0, 0, 0);
    step();
    check_output("fl_insn",  instruction_out, NOP);
    check_output("fl_valid", valid_out,       0);
    check_output("fl_req",   imem_req,        0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    check_output("drop_req", imem_req, 0);
    apply_stimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    step();
    check_output("drop_valid", valid_out,       0);
    check_output("drop_insn",  instruction_out, NOP);
    check_output("drop_req1",  imem_req,        1);
    check_output("drop_addr",  imem_addr,       32'h100);

    // flush and stall together with a valid word in IF/ID
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 1, 32'h0000_0513);
    step();
    check_output("w100_valid", valid_out, 1);
    apply_stimulus(1, 1, 32'h203, 0, 0, 0);
    step();
    check_output("fs_insn",  instruction_out, NOP);
    check_output("fs_valid", valid_out,       0);
    check_output("fs_addr",  imem_addr,       32'h200);

    // grant withheld 4 cycles at 0x20
    apply_stimulus(0, 1, 32'h20, 0, 0, 0);
    step();
    check_output("gw_addr", imem_addr, 32'h20);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("gw_req_hold",  imem_req,  1);
      check_output("gw_addr_hold", imem_addr, 32'h20);
    end
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    check_output("gw_granted_req", imem_req, 0);
    apply_stimulus(0, 0, 0, 0, 1, 32'h0010_0093);
    step();
    check_output("gw_pc",   PC_out,    32'h20);
    check_output("gw_next", imem_addr, 32'h24);

    // backward beq at 0x40
    apply_stimulus(0, 1, 32'h40, 0, 0, 0);
    step();
    check_output("bp_addr", imem_addr, 32'h40);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 1, 32'hFE00_0EE3);
    step();
`ifdef IF_STATIC_PREDICT_EN
    exp_addr = 32'h3C;
    exp_pred = 1'b1;
`else
    exp_addr = 32'h44;
    exp_pred = 1'b0;
`endif
    check_output("bp_next", imem_addr,      exp_addr);
    check_output("bp_pred", pred_taken_out, {31'd0, exp_pred});
    check_output("bp_pc",   PC_out,         32'h40);

    // PC wraps from 0xFFFF_FFFC to 0
    apply_stimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 1, 32'h0000_0093);
    step();
    check_output("wrap_pc",   PC_out,    32'hFFFF_FFFC);
    check_output("wrap_addr", imem_addr, 0);

    // asynchronous reset with a response outstanding
    apply_stimulus(0, 0, 0, 1, 0, 0);
    step();
    reset = 1'b0;
    #1;
    check_output("ar_req",   imem_req,  0);
    check_output("ar_pc",    PC_out,    0);
    check_output("ar_valid", valid_out, 0);
    apply_stimulus(0, 0, 0, 0, 1, 32'h1234_5678);
    step();
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    check_output("ar_restart_req",  imem_req,  1);
    check_output("ar_restart_addr", imem_addr, 0);
    check_output("ar_restart_insn", instruction_out, NOP);

    // flush coinciding with a grant must drop the granted response
    apply_stimulus(0, 1, 32'h80, 1, 0, 0);
    step();
    check_output("fg_req", imem_req, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    check_output("fg_drop_req", imem_req, 0);
    apply_stimulus(0, 0, 0, 0, 1, 32'h0000_0093);
    step();
    check_output("fg_valid", valid_out, 0);
    check_output("fg_req1",  imem_req,  1);
    check_output("fg_addr",  imem_addr, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
